// File: rtl/obstacle_gen_if.sv
// Obstacle generator bus: gamemode/frame_tick in, packed obstacle geometry out.
// Purely combinational bundle; no latency of its own.
// No backpressure: the consumer samples the registered buses every cycle.
interface obstacle_gen_if;
  logic [1:0]   gamemode;
  logic         frame_tick;
  logic [199:0] obstacle_x;
  logic [179:0] obstacle_y;
  logic [9:0]   active;
  logic [15:0]  passed_count;

  // Generator side: consumes mode/tick, drives geometry
  modport master (
    input  gamemode, frame_tick,
    output obstacle_x, obstacle_y, active, passed_count
  );

  // Game-logic side: drives mode/tick, consumes geometry
  modport slave (
    output gamemode, frame_tick,
    input  obstacle_x, obstacle_y, active, passed_count
  );
endinterface

// File: rtl/obstacle_gen.sv
// Spawns, scrolls and retires up to 10 obstacles on frame ticks.
// Latency: outputs update at the clk edge that samples frame_tick=1.
// No backpressure: ticks are consumed unconditionally; full table skips spawns.
module obstacle_gen #(
  parameter int          SPAWN_INTERVAL = 60,
  parameter int          SPEED          = 4,
  parameter int          SPAWN_X        = 640,
  parameter int          OBS_WIDTH      = 40,
  parameter int          MIN_LEN        = 40,
  parameter int          UPPER_BOUND    = 40,
  parameter int          LOWER_BOUND    = 480,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  obstacle_gen_if.master bus
);

  localparam logic [15:0] SI_M1  = 16'(SPAWN_INTERVAL - 1);
  localparam logic [9:0]  SPD    = 10'(SPEED);
  localparam logic [9:0]  SX_L   = 10'(SPAWN_X);
  localparam logic [9:0]  SX_R   = 10'(SPAWN_X + OBS_WIDTH);
  localparam logic [8:0]  UB     = 9'(UPPER_BOUND);
  localparam logic [8:0]  LB     = 9'(LOWER_BOUND);
  localparam logic [8:0]  MLEN   = 9'(MIN_LEN);
  localparam logic [15:0] TAPS   = 16'hB400;

  logic [9:0]  r_xl [10];
  logic [9:0]  r_xr [10];
  logic [8:0]  r_yt [10];
  logic [8:0]  r_yb [10];
  logic [9:0]  r_act;
  logic [15:0] r_passed;
  logic [15:0] r_cnt;
  logic [15:0] r_lfsr;

  logic [9:0]  w_xl [10];
  logic [9:0]  w_xr [10];
  logic [8:0]  w_yt [10];
  logic [8:0]  w_yb [10];
  logic [9:0]  w_act;
  logic [15:0] w_passed;
  logic [15:0] w_cnt;
  logic [15:0] w_lfsr;
  logic [3:0]  w_nfree;
  logic [3:0]  w_slot;
  logic        w_slot_ok;
  logic [8:0]  w_len;
  logic        w_run;
  logic [199:0] w_ox;
  logic [179:0] w_oy;

  assign w_run = (bus.gamemode == 2'b01) && bus.frame_tick;
  assign w_len = MLEN + {2'b00, r_lfsr[6:0]};

  // Next-state: scroll live slots, then spawn into the lowest slot free before this tick
  always_comb begin
    w_xl     = r_xl;
    w_xr     = r_xr;
    w_yt     = r_yt;
    w_yb     = r_yb;
    w_act    = r_act;
    w_passed = r_passed;
    w_cnt    = r_cnt;
    w_lfsr   = r_lfsr;
    w_nfree  = 4'd0;
    w_slot_ok = 1'b0;
    w_slot   = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (!r_act[i]) begin
        w_slot_ok = 1'b1;
        w_slot    = 4'(i);
      end
    end
    if (w_run) begin
      for (int i = 0; i < 10; i++) begin
        if (r_act[i]) begin
          if (r_xr[i] <= SPD) begin
            w_xl[i]  = '0;
            w_xr[i]  = '0;
            w_yt[i]  = '0;
            w_yb[i]  = '0;
            w_act[i] = 1'b0;
            w_nfree  = w_nfree + 4'd1;
          end else begin
            w_xr[i] = r_xr[i] - SPD;
            w_xl[i] = (r_xl[i] < SPD) ? 10'd0 : r_xl[i] - SPD;
          end
        end
      end
      w_passed = r_passed + {12'd0, w_nfree};
      if (r_cnt == SI_M1) begin
        w_cnt = '0;
        // Spawn fields use the pre-advance LFSR value; a skipped attempt still advances it
        for (int i = 0; i < 10; i++) begin
          if (w_slot_ok && (w_slot == 4'(i))) begin
            w_xl[i]  = SX_L;
            w_xr[i]  = SX_R;
            w_yt[i]  = r_lfsr[15] ? (LB - w_len) : UB;
            w_yb[i]  = r_lfsr[15] ? LB : (UB + w_len);
            w_act[i] = 1'b1;
          end
        end
        w_lfsr = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
      end else begin
        w_cnt = r_cnt + 16'd1;
      end
    end
  end

  // State registers: async reset and gamemode 00 clear everything; 10/11 hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        r_xl[i] <= '0;
        r_xr[i] <= '0;
        r_yt[i] <= '0;
        r_yb[i] <= '0;
      end
      r_act    <= '0;
      r_passed <= '0;
      r_cnt    <= '0;
      r_lfsr   <= SEED;
    end else if (bus.gamemode == 2'b00) begin
      for (int i = 0; i < 10; i++) begin
        r_xl[i] <= '0;
        r_xr[i] <= '0;
        r_yt[i] <= '0;
        r_yb[i] <= '0;
      end
      r_act    <= '0;
      r_passed <= '0;
      r_cnt    <= '0;
      r_lfsr   <= SEED;
    end else begin
      r_xl     <= w_xl;
      r_xr     <= w_xr;
      r_yt     <= w_yt;
      r_yb     <= w_yb;
      r_act    <= w_act;
      r_passed <= w_passed;
      r_cnt    <= w_cnt;
      r_lfsr   <= w_lfsr;
    end
  end

  // Pack slot registers onto the output buses
  always_comb begin
    w_ox = '0;
    w_oy = '0;
    for (int i = 0; i < 10; i++) begin
      w_ox[20*i +: 10]    = r_xl[i];
      w_ox[20*i+10 +: 10] = r_xr[i];
      w_oy[18*i +: 9]     = r_yt[i];
      w_oy[18*i+9 +: 9]   = r_yb[i];
    end
  end

  assign bus.obstacle_x   = w_ox;
  assign bus.obstacle_y   = w_oy;
  assign bus.active       = r_act;
  assign bus.passed_count = r_passed;

endmodule
